quad_step_decoder: RTL and testbench
====================================

# quad_step_decoder

Quadrature front end that turns a two-channel rotary encoder (A/B) into the single-cycle `up`/`down` step pulses consumed by the 4-bit up/down counter. It synchronizes and debounces both raw channels, tracks the Gray-code phase, and emits one step pulse per legal quarter-step. It sits between the board pins and the counter, and supplies the counter's control inputs.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized samples required before a channel's filtered value changes. Legal range 1..255.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `a_in`  in  1  raw encoder channel A; asynchronous, may bounce.
- `b_in`  in  1  raw encoder channel B; asynchronous, may bounce.
- `en`  in  1  step-output enable. When low, `up`/`down` are forced to 0 and phase tracking continues.
- `up`  out  1  one-cycle pulse per forward quarter-step. Reset 0.
- `down`  out  1  one-cycle pulse per reverse quarter-step. Reset 0.
- `dir`  out  1  direction of the last emitted step: 1 = up, 0 = down. Reset 0.
- `err`  out  1  one-cycle pulse on an illegal phase jump. Reset 0. Present only when `QUAD_ERR_EN` is defined; otherwise tied to 0.

## Operation
- Per channel, a 2-flop synchronizer feeds a debounce filter.
- Filter behaviour:
  - Counter width is $clog2(DEB_CYCLES+1).
  - The counter clears whenever the synchronized sample equals the filtered value.
  - The counter increments while the two differ.
  - When the counter reaches DEB_CYCLES, the filtered value takes the sample and the counter clears.
- Phase state is the filtered pair {A,B}. Forward order is 00→01→11→10→00; reverse order is 00→10→11→01→00.
- Each legal forward transition sets `up`=1 and `dir`=1 for one cycle. Each legal reverse transition sets `down`=1 and `dir`=0 for one cycle.
- A two-bit jump (00↔11 or 01↔10) is illegal:
  - No `up`/`down` pulse.
  - `dir` is unchanged.
  - The phase register resyncs to the new value.
  - `err` pulses if the error feature is compiled in.
- No change in the filtered pair produces no output.
- `up` and `down` are never high in the same cycle.
- Seed phase after reset:
  - A seed flag clears on reset.
  - For the first DEB_CYCLES+2 cycles after reset release, both filtered values and the phase register load the synchronized samples directly, with no pulses and no error.
  - After that the flag sets and normal decoding begins.
  - This prevents a spurious step or error when the encoder rests at a non-00 detent.
- `en` low blocks the pulse outputs only. Phase tracking continues, so re-asserting `en` never produces a catch-up pulse. `dir` does not update while `en` is low.
- Outputs are registered; there are no combinational input-to-output paths.

## Timing
- Raw edge captured at clock edge 0:
  - The synchronized value is valid after edge 1.
  - The filtered value updates at edge 1+DEB_CYCLES.
  - `up`/`down` go high after edge 2+DEB_CYCLES and stay high for exactly one cycle.
  - Latency is 6 cycles at the default.
- A bounce shorter than DEB_CYCLES cycles is fully rejected.
- Maximum step rate is one step per DEB_CYCLES+1 cycles per channel.
- Reset mid-operation:
  - All outputs go to 0 asynchronously.
  - Filter counters and synchronizers clear.
  - The seed phase re-runs.
- Simultaneous filtered change on both channels in one cycle is treated as an illegal jump; see Operation.

## Configuration
- `QUAD_ERR_EN` defined:
  - `err` is driven as specified.
  - A sticky internal error count is excluded from the port list.
- `QUAD_ERR_EN` undefined:
  - `err` is constant 0.
  - Illegal jumps still suppress pulses and resync the phase register.

## Structure
- Package `quad_pkg` holds:
  - Phase encodings: PH_00, PH_01, PH_11, PH_10.
  - The step-kind enum: STEP_NONE, STEP_UP, STEP_DOWN, STEP_ILLEGAL.
  - The function mapping {previous phase, current phase} → step kind.
- Sub-module `quad_deb_filter`: one channel's synchronizer plus debounce filter, parameterized by DEB_CYCLES. It is instantiated twice, once for A and once for B.
- Top level holds the seed logic, phase register, step decode, and output registers.

## Test plan
- Reset, then A/B held at 11 for 20 cycles → no `up`, `down`, or `err`; the phase register settles at 11.
- Clean forward sequence 00→01→11→10→00, each held 10 cycles, `en`=1 → four `up` pulses, each one cycle long and 6 cycles after the raw edge; `dir`=1; `down` stays 0.
- Reverse sequence of 8 steps → eight `down` pulses; `dir`=0; a downstream counter starting at 0 wraps to 4'd8.
- A bounces 3 cycles high/low around a real transition, DEB_CYCLES=4 → exactly one `up` pulse; the 3-cycle glitch alone produces nothing.
- A and B both flip 00→11 in the same cycle → no step; `err`=1 for one cycle with `QUAD_ERR_EN` defined, 0 without it; the next legal step decodes correctly.
- `en`=0 during two forward steps, then `en`=1 → no pulses and no catch-up; the next step produces one `up`. A separate case asserts `rst` mid-step → outputs 0 immediately.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg: phase encodings, step kinds and the phase-transition classifier for quad_step_decoder
package quad_pkg;
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;
  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DOWN, STEP_ILLEGAL} step_t;
  function automatic logic [1:0] fwd_next(input logic [1:0] p);
    return p == PH_00 ? PH_01 : p == PH_01 ? PH_11 : p == PH_11 ? PH_10 : PH_00;
  endfunction
  function automatic step_t step_of(input logic [1:0] prev, input logic [1:0] cur);
    return cur == prev ? STEP_NONE :
           (cur ^ prev) == 2'b11 ? STEP_ILLEGAL :
           cur == fwd_next(prev) ? STEP_UP : STEP_DOWN;
  endfunction
endpackage

// File: rtl/quad_deb_filter.sv
// quad_deb_filter: 2-flop synchronizer plus debounce filter for one encoder channel
//   clk, rst (async, active-high); din raw channel; load forces filt to the synchronized sample;
//   sync synchronized sample; filt debounced value.
module quad_deb_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic load,
  output logic sync,
  output logic filt
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1;
  logic [CW-1:0] cnt;
  // The count runs while sync differs from filt; the DEB_CYCLES-th differing sample commits it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1   <= 1'b0;
      sync <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= din;
      sync <= s1;
      if (load) begin
        filt <= sync;
        cnt  <= '0;
      end else if (sync == filt) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        filt <= sync;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: debounced quadrature decoder producing registered up/down step pulses
//   clk, rst (async, active-high); a_in, b_in raw encoder channels; en step-output enable;
//   up/down one-cycle step pulses; dir last emitted direction (1 = up); err illegal-jump pulse,
//   driven only when QUAD_ERR_EN is defined, otherwise constant 0.
module quad_step_decoder import quad_pkg::*; #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  input  logic en,
  output logic up,
  output logic down,
  output logic dir,
  output logic err
);
  localparam int SW = $clog2(DEB_CYCLES + 2);
  logic sa, sb, fa, fb, seeded;
  logic [SW-1:0] seed_cnt;
  logic [1:0] phase;
  step_t st;
  quad_deb_filter #(.DEB_CYCLES(DEB_CYCLES)) u_a (
    .clk(clk), .rst(rst), .din(a_in), .load(!seeded), .sync(sa), .filt(fa)
  );
  quad_deb_filter #(.DEB_CYCLES(DEB_CYCLES)) u_b (
    .clk(clk), .rst(rst), .din(b_in), .load(!seeded), .sync(sb), .filt(fb)
  );
  assign st = step_of(phase, {fa, fb});
  // Until seeded, filters and phase track the synchronized pins so a resting non-00 detent
  // never looks like a step; phase keeps tracking regardless of en so there is no catch-up.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seeded   <= 1'b0;
      seed_cnt <= '0;
      phase    <= PH_00;
      up       <= 1'b0;
      down     <= 1'b0;
      dir      <= 1'b0;
    end else begin
      up   <= 1'b0;
      down <= 1'b0;
      if (!seeded) begin
        seed_cnt <= seed_cnt + 1'b1;
        seeded   <= seed_cnt == SW'(DEB_CYCLES + 1);
        phase    <= {sa, sb};
      end else begin
        phase <= {fa, fb};
        if (en && st == STEP_UP) begin
          up  <= 1'b1;
          dir <= 1'b1;
        end
        if (en && st == STEP_DOWN) begin
          down <= 1'b1;
          dir  <= 1'b0;
        end
      end
    end
`ifdef QUAD_ERR_EN
  logic err_q;
  logic [7:0] err_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q <= seeded && st == STEP_ILLEGAL;
      if (seeded && st == STEP_ILLEGAL && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: table-driven check of quad_step_decoder at DEB_CYCLES=4
module tb_quad_step_decoder;
  logic clk = 1'b0, rst = 1'b1, a_in = 1'b1, b_in = 1'b1, en = 1'b1;
  logic up, down, dir, err;
  int checks = 0, errors = 0, both_hi = 0;
  logic [3:0] cnt4;
`ifdef QUAD_ERR_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif
  typedef struct {
    logic a, b, e;
    int nu, nd;
    logic d;
    int ne;
  } vec_t;
  vec_t tbl[21];
  quad_step_decoder #(.DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .en(en),
    .up(up), .down(down), .dir(dir), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Runs n cycles, sampling at each negedge; first = index of the first sampled pulse.
  task automatic run(input int n, output int nu, output int nd, output int ne, output int first);
    nu = 0; nd = 0; ne = 0; first = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (up && down) both_hi++;
      if ((up || down || err) && first < 0) first = k;
      nu += int'(up);
      nd += int'(down);
      ne += int'(err);
    end
  endtask
  initial begin
    int nu, nd, ne, first, tu, td, te;
    tbl[0]  = '{1, 0, 1, 1, 0, 1, 0};
    tbl[1]  = '{0, 0, 1, 1, 0, 1, 0};
    tbl[2]  = '{0, 1, 1, 1, 0, 1, 0};
    tbl[3]  = '{1, 1, 1, 1, 0, 1, 0};
    tbl[4]  = '{1, 0, 1, 1, 0, 1, 0};
    tbl[5]  = '{0, 0, 1, 1, 0, 1, 0};
    tbl[6]  = '{1, 0, 1, 0, 1, 0, 0};
    tbl[7]  = '{1, 1, 1, 0, 1, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[11] = '{1, 1, 1, 0, 1, 0, 0};
    tbl[12] = '{0, 1, 1, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 1, 0, 1, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 1, 1, 0, 0, 0, 0};
    tbl[17] = '{1, 0, 1, 1, 0, 1, 0};
    tbl[18] = '{0, 0, 1, 1, 0, 1, 0};
    tbl[19] = '{1, 1, 1, 0, 0, 1, ERR_EXP};
    tbl[20] = '{1, 0, 1, 1, 0, 1, 0};
    repeat (2) @(negedge clk);
    chk("reset_up", int'(up), 0);
    chk("reset_down", int'(down), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_err", int'(err), 0);
    rst = 1'b0;
    run(20, nu, nd, ne, first);
    chk("seed11_pulses", nu + nd + ne, 0);
    chk("seed11_phase", int'(dut.phase), 3);
    cnt4 = 4'd0;
    for (int i = 0; i < 21; i++) begin
      if (i == 6) cnt4 = 4'd0;
      a_in = tbl[i].a; b_in = tbl[i].b; en = tbl[i].e;
      run(10, nu, nd, ne, first);
      cnt4 = cnt4 + 4'(nu) - 4'(nd);
      chk($sformatf("v%0d_up", i), nu, tbl[i].nu);
      chk($sformatf("v%0d_down", i), nd, tbl[i].nd);
      chk($sformatf("v%0d_err", i), ne, tbl[i].ne);
      chk($sformatf("v%0d_dir", i), int'(dir), int'(tbl[i].d));
      if (tbl[i].nu + tbl[i].nd + tbl[i].ne > 0) chk($sformatf("v%0d_latency", i), first, 6);
      if (i == 13) chk("rev_counter", int'(cnt4), 8);
    end
    a_in = 1'b0;
    run(3, nu, nd, ne, first);
    a_in = 1'b1;
    run(15, tu, td, te, first);
    chk("glitch_pulses", nu + nd + ne + tu + td + te, 0);
    a_in = 1'b0;
    run(3, nu, nd, ne, first);
    a_in = 1'b1;
    run(3, tu, td, te, first);
    nu += tu; nd += td; ne += te;
    a_in = 1'b0;
    run(15, tu, td, te, first);
    chk("bounce_up", nu + tu, 1);
    chk("bounce_down", nd + td, 0);
    chk("bounce_dir", int'(dir), 1);
    b_in = 1'b1;
    run(7, nu, nd, ne, first);
    chk("midstep_up_before_rst", int'(up), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_up", int'(up), 0);
    chk("rst_async_dir", int'(dir), 0);
    @(negedge clk);
    rst = 1'b0;
    run(20, nu, nd, ne, first);
    chk("reseed_pulses", nu + nd + ne, 0);
    chk("reseed_phase", int'(dut.phase), 1);
    a_in = 1'b1;
    run(10, nu, nd, ne, first);
    chk("post_rst_up", nu, 1);
    chk("post_rst_latency", first, 6);
    chk("post_rst_dir", int'(dir), 1);
    chk("up_down_overlap", both_hi, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
